fetch_controller: RTL and testbench
===================================

// Module: fetch_controller
// PURPOSE
//  Fetch-stage sequencer. Owns the PC register and the instruction-memory request (iREN/iaddr).
//  Selects next PC: sequential, branch, jump or JR. Handles redirects that arrive while a request
//  is outstanding, decode back-pressure and halt. Sits between the icache/memory-control port and decode.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC value loaded on reset
// PORTS
//  CLK           in   1   clock, rising edge
//  nRST          in   1   asynchronous active-low reset
//  ihit          in   1   memory returns iload for current iaddr this cycle
//  iload         in   32  instruction word from memory
//  iREN          out  1   instruction read request
//  iaddr         out  32  request address (= PC)
//  stall         in   1   decode cannot accept instr this cycle
//  redir_valid   in   1   execute resolved a taken control transfer
//  redir_sel     in   2   pcsel_t: PC_BR=1, PC_J=2, PC_JR=3 (0 = PC_SEQ, ignored)
//  redir_base    in   32  PC of the control instruction
//  bimm          in   16  branch offset in words, signed
//  jimm          in   26  jump index
//  jraddr        in   32  JR target register value
//  halt          in   1   stop fetching (sticky until reset)
//  instr_valid   out  1   instr/instr_pc valid for decode
//  instr         out  32  fetched instruction
//  instr_pc      out  32  address instr was fetched from
//  halted        out  1   controller in HALT
// BEHAVIOUR
//  Reset: PC=RESET_PC, state=IDLE, iREN=0, instr_valid=0, instr=0, instr_pc=0, halted=0, drop=0.
//  Targets: BR = redir_base + {{14{bimm[15]}},bimm,2'b00}; J = {4'b0,jimm,2'b00}; JR = jraddr.
//  All address arithmetic is 32-bit and wraps modulo 2^32. PC+4 at 32'hFFFF_FFFC gives 0.
//  iaddr = PC always. iREN = 1 in FETCH and DRAIN only.
//  States:
//   IDLE  -> FETCH next cycle (one bubble after reset).
//   FETCH: request held stable until ihit.
//     On ihit, no redir, no drop: instr<=iload, instr_pc<=PC, instr_valid<=1, PC<=PC+4.
//       Next state: HOLD if stall else FETCH.
//     On ihit with drop=1: word discarded, drop cleared, PC unchanged, stays FETCH.
//   HOLD: outputs held and instr_valid=1 while stall=1. When stall=0, go to FETCH
//     (instr_valid drops next cycle unless a new ihit lands).
//   DRAIN: entered when a redirect arrives in FETCH with no ihit. iaddr is held (memory requires
//     a stable address). On ihit the word is discarded, PC<=saved target, state -> FETCH.
//   HALT: iREN=0, instr_valid=0, halted=1. Exit only via nRST.
//  Redirect (redir_valid && redir_sel!=0), by cycle:
//   - FETCH, same cycle as ihit: iload discarded, instr_valid<=0, PC<=target.
//   - FETCH, no ihit: target saved in tgt_q, state -> DRAIN.
//   - HOLD/IDLE: PC<=target, instr_valid<=0 (held instr squashed), state -> FETCH.
//   - DRAIN: tgt_q overwritten; the youngest redirect wins.
//  Priority: nRST > halt > redirect > ihit > stall.
//   halt in FETCH/DRAIN is deferred until ihit (no abandoned request), then -> HALT.
//  stall never blocks a redirect. Reset mid-request returns to IDLE immediately; memory sees iREN fall.
// CONFIGURATION
//  FETCH_PERF_EN defined: adds outputs fetch_cnt[31:0] and squash_cnt[31:0].
//   fetch_cnt counts instr_valid rising deliveries; squash_cnt counts discarded words plus squashed HOLD.
//   Both reset to 0 and saturate at 32'hFFFF_FFFF.
//  FETCH_PERF_EN undefined: no ports, no counter logic.
// STRUCTURE
//  cpu_types_pkg: word_t (existing); add pcsel_t {PC_SEQ,PC_BR,PC_J,PC_JR} and
//   fetch_state_t {IDLE,FETCH,HOLD,DRAIN,HALT}.
//  Sub-module next_pc_gen (combinational): inputs sel, pc, base, bimm, jimm, jraddr; output target word_t.
// TESTING
//  1 Reset, ihit every cycle, iload=i -> IDLE bubble, then instr_pc 0,4,8,C; iREN=1 from cycle 2.
//  2 stall=1 for 3 cycles after fetch @0x8 -> instr/instr_pc held, iREN=0, PC=0xC; resume fetches 0xC.
//  3 Redirect BR, base=0x10, bimm=-2, with ihit -> word dropped, next iaddr=0x08.
//  4 Redirect J jimm=0x40 while ihit=0 (3-cycle miss) -> DRAIN; iaddr stays old, returned word dropped;
//    then iaddr=0x100.
//  5 JR jraddr=0xFFFF_FFFC then sequential -> iaddr wraps to 0x0.
//  6 halt during miss -> iREN held until ihit, then halted=1, iREN=0. nRST mid-HALT -> PC=RESET_PC.

Source files
------------

// File: rtl/fetch_controller_pkg.sv
// Shared types for the fetch stage: word type, PC-select codes and fetch FSM encodings.
// Used by fetch_controller, next_pc_gen and fetch_controller_if.
package fetch_controller_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        PC_SEQ = 2'd0,
        PC_BR  = 2'd1,
        PC_J   = 2'd2,
        PC_JR  = 2'd3
    } pcsel_t;

    typedef logic [2:0] fetch_state_t;

    localparam fetch_state_t IDLE  = 3'd0;
    localparam fetch_state_t FETCH = 3'd1;
    localparam fetch_state_t HOLD  = 3'd2;
    localparam fetch_state_t DRAIN = 3'd3;
    localparam fetch_state_t HALT  = 3'd4;

    localparam word_t INSTR_BYTES = 32'd4;

    // Saturating increment for the optional performance counters.
    function automatic word_t sat_inc(input word_t v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/fetch_controller_if.sv
// Fetch-stage bundle: instruction-memory port, redirect/halt from execute and the decode handoff.
// master = fetch_controller, slave = its environment (memory, execute, decode).
interface fetch_controller_if;
    import fetch_controller_pkg::*;

    logic       ihit;
    word_t      iload;
    logic       iREN;
    word_t      iaddr;
    logic       stall;
    logic       redir_valid;
    pcsel_t     redir_sel;
    word_t      redir_base;
    logic [15:0] bimm;
    logic [25:0] jimm;
    word_t      jraddr;
    logic       halt;
    logic       instr_valid;
    word_t      instr;
    word_t      instr_pc;
    logic       halted;

    modport master (
        input  ihit, iload, stall, redir_valid, redir_sel, redir_base, bimm, jimm, jraddr, halt,
        output iREN, iaddr, instr_valid, instr, instr_pc, halted
    );

    modport slave (
        output ihit, iload, stall, redir_valid, redir_sel, redir_base, bimm, jimm, jraddr, halt,
        input  iREN, iaddr, instr_valid, instr, instr_pc, halted
    );

endinterface

// File: rtl/fetch_controller_next_pc_gen.sv
// Combinational next-PC selector: sequential, branch, jump or register-indirect target.
module next_pc_gen
    import fetch_controller_pkg::*;
(
    input  pcsel_t      sel,
    input  word_t       pc,
    input  word_t       base,
    input  logic [15:0] bimm,
    input  logic [25:0] jimm,
    input  word_t       jraddr,
    output word_t       target
);

    always_comb begin
        target = pc + INSTR_BYTES;
        unique case (sel)
            PC_SEQ:  target = pc + INSTR_BYTES;
            PC_BR:   target = base + {{14{bimm[15]}}, bimm, 2'b00};
            PC_J:    target = {4'b0000, jimm, 2'b00};
            PC_JR:   target = jraddr;
            default: target = pc + INSTR_BYTES;
        endcase
    end

endmodule

// File: rtl/fetch_controller.sv
// Fetch-stage sequencer: owns the PC and the instruction-memory request, handles redirects,
// decode back-pressure and halt. Optional counters enabled by defining FETCH_PERF_EN.
module fetch_controller
    import fetch_controller_pkg::*;
#(
    parameter word_t RESET_PC = 32'h0000_0000
) (
    input  logic                CLK,
    input  logic                nRST,
    fetch_controller_if.master  bus_io
`ifdef FETCH_PERF_EN
    ,
    output word_t               fetch_cnt,
    output word_t               squash_cnt
`endif
);

    fetch_state_t state_q, state_d;
    word_t        pc_q, pc_d;
    word_t        tgt_q, tgt_d;
    word_t        instr_q, instr_d;
    word_t        instr_pc_q, instr_pc_d;
    logic         valid_q, valid_d;
    logic         halt_pend_q, halt_pend_d;

    logic   redir;
    logic   halt_req;
    pcsel_t gen_sel;
    word_t  gen_target;

    assign redir    = bus_io.redir_valid && (bus_io.redir_sel != PC_SEQ);
    assign halt_req = bus_io.halt || halt_pend_q;
    assign gen_sel  = redir ? bus_io.redir_sel : PC_SEQ;

    next_pc_gen u_next_pc_gen (
        .sel    (gen_sel),
        .pc     (pc_q),
        .base   (bus_io.redir_base),
        .bimm   (bus_io.bimm),
        .jimm   (bus_io.jimm),
        .jraddr (bus_io.jraddr),
        .target (gen_target)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        tgt_d       = tgt_q;
        instr_d     = instr_q;
        instr_pc_d  = instr_pc_q;
        valid_d     = valid_q;
        halt_pend_d = halt_pend_q;

        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                if (halt_req) begin
                    state_d = HALT;
                end else begin
                    state_d = FETCH;
                    if (redir) pc_d = gen_target;
                end
            end

            FETCH: begin
                valid_d = 1'b0;
                if (bus_io.ihit) begin
                    if (halt_req) begin
                        state_d = HALT;
                    end else if (redir) begin
                        pc_d = gen_target;
                    end else begin
                        // No redirect, so gen_target is the sequential PC+4.
                        valid_d    = 1'b1;
                        instr_d    = bus_io.iload;
                        instr_pc_d = pc_q;
                        pc_d       = gen_target;
                        state_d    = bus_io.stall ? HOLD : FETCH;
                    end
                end else begin
                    halt_pend_d = halt_req;
                    if (redir) begin
                        tgt_d   = gen_target;
                        state_d = DRAIN;
                    end
                end
            end

            HOLD: begin
                if (halt_req) begin
                    valid_d = 1'b0;
                    state_d = HALT;
                end else if (redir) begin
                    valid_d = 1'b0;
                    pc_d    = gen_target;
                    state_d = FETCH;
                end else if (!bus_io.stall) begin
                    valid_d = 1'b0;
                    state_d = FETCH;
                end
            end

            DRAIN: begin
                valid_d = 1'b0;
                if (bus_io.ihit) begin
                    if (halt_req) begin
                        state_d = HALT;
                    end else begin
                        // A redirect landing with the stale word is younger than tgt_q.
                        pc_d    = redir ? gen_target : tgt_q;
                        state_d = FETCH;
                    end
                end else begin
                    halt_pend_d = halt_req;
                    if (redir) tgt_d = gen_target;
                end
            end

            HALT: begin
                valid_d = 1'b0;
            end

            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            tgt_q       <= '0;
            instr_q     <= '0;
            instr_pc_q  <= '0;
            valid_q     <= 1'b0;
            halt_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            tgt_q       <= tgt_d;
            instr_q     <= instr_d;
            instr_pc_q  <= instr_pc_d;
            valid_q     <= valid_d;
            halt_pend_q <= halt_pend_d;
        end
    end

    assign bus_io.iREN        = (state_q == FETCH) || (state_q == DRAIN);
    assign bus_io.iaddr       = pc_q;
    assign bus_io.instr_valid = valid_q;
    assign bus_io.instr       = instr_q;
    assign bus_io.instr_pc    = instr_pc_q;
    assign bus_io.halted      = (state_q == HALT);

`ifdef FETCH_PERF_EN
    logic  deliver, discard, squash_hold;
    word_t fetch_cnt_q, squash_cnt_q;

    assign deliver     = (state_q == FETCH) && bus_io.ihit && !halt_req && !redir;
    assign discard     = bus_io.ihit &&
                         ((state_q == DRAIN) || ((state_q == FETCH) && (halt_req || redir)));
    assign squash_hold = (state_q == HOLD) && !halt_req && redir;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            fetch_cnt_q  <= '0;
            squash_cnt_q <= '0;
        end else begin
            if (deliver) fetch_cnt_q <= sat_inc(fetch_cnt_q);
            if (discard || squash_hold) squash_cnt_q <= sat_inc(squash_cnt_q);
        end
    end

    assign fetch_cnt  = fetch_cnt_q;
    assign squash_cnt = squash_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: directed scenarios plus randomized traffic
// compared every cycle against a flag-based behavioural model.
module tb_fetch_controller;
    import fetch_controller_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fetch_controller_if bus ();

`ifdef FETCH_PERF_EN
    word_t fetch_cnt, squash_cnt;
`endif

    fetch_controller #(
        .RESET_PC (32'h0000_0000)
    ) dut (
        .CLK    (clk),
        .nRST   (rst_n),
        .bus_io (bus)
`ifdef FETCH_PERF_EN
        ,
        .fetch_cnt  (fetch_cnt),
        .squash_cnt (squash_cnt)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: started = bubble done, hold = decode holding, have = redirect waiting on stale word.
    logic        m_started, m_hold, m_halted, m_hpend, m_have, m_valid;
    logic [31:0] m_pc, m_tgt, m_instr, m_ipc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_target(input logic [1:0] sel, input logic [31:0] base,
                                               input logic [15:0] bimm, input logic [25:0] jimm,
                                               input logic [31:0] jr);
        int off;
        off = int'($signed(bimm)) * 4;
        case (sel)
            2'd1:    return base + 32'(off);
            2'd2:    return 32'(jimm) * 32'd4;
            default: return jr;
        endcase
    endfunction

    task automatic model_reset();
        m_started = 1'b0; m_hold = 1'b0; m_halted = 1'b0; m_hpend = 1'b0;
        m_have = 1'b0; m_valid = 1'b0;
        m_pc = 32'h0; m_tgt = 32'h0; m_instr = 32'h0; m_ipc = 32'h0;
    endtask

    task automatic model_step();
        logic        rdr, hp;
        logic [31:0] t;
        rdr = bus.redir_valid && (bus.redir_sel != PC_SEQ);
        t   = ref_target(2'(bus.redir_sel), bus.redir_base, bus.bimm, bus.jimm, bus.jraddr);
        hp  = bus.halt || m_hpend;
        if (m_halted) begin
            m_valid = 1'b0;
        end else if (!m_started) begin
            m_started = 1'b1;
            m_valid   = 1'b0;
            if (bus.halt) m_halted = 1'b1;
            else if (rdr) m_pc = t;
        end else if (m_hold) begin
            if (hp) begin
                m_halted = 1'b1; m_valid = 1'b0;
            end else if (rdr) begin
                m_pc = t; m_valid = 1'b0; m_hold = 1'b0;
            end else if (!bus.stall) begin
                m_valid = 1'b0; m_hold = 1'b0;
            end
        end else if (bus.ihit) begin
            m_valid = 1'b0;
            if (hp) begin
                m_halted = 1'b1;
            end else if (rdr) begin
                m_pc = t; m_have = 1'b0;
            end else if (m_have) begin
                m_pc = m_tgt; m_have = 1'b0;
            end else begin
                m_valid = 1'b1; m_instr = bus.iload; m_ipc = m_pc;
                m_pc = m_pc + 32'd4; m_hold = bus.stall;
            end
        end else begin
            m_valid = 1'b0;
            if (bus.halt) m_hpend = 1'b1;
            if (rdr) begin
                m_have = 1'b1; m_tgt = t;
            end
        end
    endtask

    task automatic compare_all();
        logic e_iren;
        e_iren = m_started && !m_hold && !m_halted;
        check("iren", 32'(bus.iREN), 32'(e_iren));
        check("iaddr", bus.iaddr, m_pc);
        check("valid", 32'(bus.instr_valid), 32'(m_valid));
        check("instr", bus.instr, m_instr);
        check("instr_pc", bus.instr_pc, m_ipc);
        check("halted", 32'(bus.halted), 32'(m_halted));
    endtask

    task automatic clear_inputs();
        bus.ihit = 1'b0; bus.iload = '0; bus.stall = 1'b0; bus.redir_valid = 1'b0;
        bus.redir_sel = PC_SEQ; bus.redir_base = '0; bus.bimm = '0; bus.jimm = '0;
        bus.jraddr = '0; bus.halt = 1'b0;
    endtask

    // Called at a negedge: asserts reset asynchronously, checks, releases at next negedge.
    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        int halted_cycles;
        rst_n = 1'b1;
        clear_inputs();
        model_reset();
        #2;
        do_reset();

        // Sequential fetch after the reset bubble.
        bus.ihit = 1'b1;
        cycle();
        check("t1_iren_c1", 32'(bus.iREN), 32'd1);
        check("t1_valid_c1", 32'(bus.instr_valid), 32'd0);
        for (int k = 0; k < 2; k++) begin
            bus.iload = 32'(k);
            cycle();
            check("t1_ipc", bus.instr_pc, 32'(k * 4));
        end

        // Decode stall while 0x8 is delivered.
        bus.iload = 32'd2;
        bus.stall = 1'b1;
        cycle();
        check("t2_ipc", bus.instr_pc, 32'h8);
        check("t2_iaddr", bus.iaddr, 32'hC);
        check("t2_iren", 32'(bus.iREN), 32'd0);
        cycle();
        cycle();
        check("t2_hold_ipc", bus.instr_pc, 32'h8);
        check("t2_hold_instr", bus.instr, 32'd2);
        check("t2_hold_valid", 32'(bus.instr_valid), 32'd1);
        bus.stall = 1'b0;
        cycle();
        check("t2_release_valid", 32'(bus.instr_valid), 32'd0);
        bus.iload = 32'd3;
        cycle();
        check("t2_resume_ipc", bus.instr_pc, 32'hC);

        // Branch redirect coincident with ihit: 0x10 + (-2 words) = 0x08.
        bus.redir_valid = 1'b1; bus.redir_sel = PC_BR;
        bus.redir_base = 32'h10; bus.bimm = 16'hFFFE;
        cycle();
        check("t3_valid", 32'(bus.instr_valid), 32'd0);
        check("t3_iaddr", bus.iaddr, 32'h8);

        // Jump redirect during a miss: drain the stale request first.
        bus.ihit = 1'b0; bus.redir_sel = PC_J; bus.jimm = 26'h40;
        cycle();
        bus.redir_valid = 1'b0;
        check("t4_drain_iaddr", bus.iaddr, 32'h8);
        cycle();
        cycle();
        check("t4_drain_iren", 32'(bus.iREN), 32'd1);
        check("t4_drain_iaddr2", bus.iaddr, 32'h8);
        bus.ihit = 1'b1; bus.iload = 32'hDEAD_BEEF;
        cycle();
        check("t4_iaddr", bus.iaddr, 32'h100);
        check("t4_valid", 32'(bus.instr_valid), 32'd0);

        // JR to the top word, then wrap.
        bus.redir_valid = 1'b1; bus.redir_sel = PC_JR; bus.jraddr = 32'hFFFF_FFFC;
        cycle();
        check("t5_iaddr", bus.iaddr, 32'hFFFF_FFFC);
        bus.redir_valid = 1'b0; bus.iload = 32'h55;
        cycle();
        check("t5_ipc", bus.instr_pc, 32'hFFFF_FFFC);
        check("t5_wrap", bus.iaddr, 32'h0);

        // Halt pulse during a miss waits for the outstanding word.
        bus.ihit = 1'b0; bus.halt = 1'b1;
        cycle();
        bus.halt = 1'b0;
        cycle();
        check("t6_iren_held", 32'(bus.iREN), 32'd1);
        check("t6_not_halted", 32'(bus.halted), 32'd0);
        bus.ihit = 1'b1;
        cycle();
        check("t6_halted", 32'(bus.halted), 32'd1);
        check("t6_iren", 32'(bus.iREN), 32'd0);
        cycle();
        do_reset();
        check("t6_rst_pc", bus.iaddr, 32'h0);
        check("t6_rst_halted", 32'(bus.halted), 32'd0);

        // Randomized traffic with occasional resets.
        halted_cycles = 0;
        for (int n = 0; n < 3000; n++) begin
            if (halted_cycles > 15 || $urandom_range(199) == 0) begin
                do_reset();
                halted_cycles = 0;
            end else begin
                bus.ihit        = bus.iREN && ($urandom_range(9) < 6);
                bus.iload       = $urandom;
                bus.stall       = ($urandom_range(9) < 3);
                bus.redir_valid = ($urandom_range(99) < 15);
                bus.redir_sel   = pcsel_t'($urandom_range(3));
                bus.redir_base  = $urandom;
                bus.bimm        = 16'($urandom);
                bus.jimm        = 26'($urandom);
                bus.jraddr      = $urandom;
                bus.halt        = ($urandom_range(99) == 0);
                cycle();
                if (m_halted) halted_cycles++;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
